ws2812_pixel_writer: RTL and testbench

Downstream stage of the WS2812 receiver. Consumes its byte stream (`rx_data`/`rx_strobe`/`frame_sync`) and groups bytes in G,R,B order into 24-bit pixels. Writes each pixel into one bank of an external double-buffered frame RAM and swaps banks when a complete frame has landed. The display scan side reads bank `~wr_bank`.

---
 rtl/ws2812_pixel_writer.sv | 138 +++++++++++++
 tb/tb_ws2812_pixel_writer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_pixel_writer.sv
// Packs the WS2812 receiver's G,R,B byte stream into 24-bit pixels and writes them
// into one bank of a double-buffered frame RAM. Banks swap only after a complete frame.
module ws2812_pixel_writer #(
  parameter int NUM_PIXELS = 1152,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  CLK_40,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_strobe,
  input  logic                  frame_sync,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [23:0]           wr_data,
  output logic                  wr_bank,
  output logic                  frame_done,
  output logic                  short_frame,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] pixel_count
);

  // state | meaning
  // IDLE  | after reset, waiting for the first frame_sync rise; bytes ignored
  // RECV  | accumulating bytes into pixels
  // DONE  | full frame written; further bytes only raise overflow
  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(NUM_PIXELS - 1);

  state_t                state_q;
  logic [2:0]            strb_sync_q;
  logic [2:0]            fsync_sync_q;
  logic [1:0]            phase_q;
  logic [7:0]            g_q;
  logic [7:0]            r_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [23:0]           wr_data_q;
  logic                  wr_bank_q;
  logic                  frame_done_q;
  logic                  short_frame_q;
  logic                  overflow_q;
  logic [ADDR_WIDTH-1:0] pixel_count_q;

  logic strb_rise;
  logic fsync_rise;

  assign strb_rise  = strb_sync_q[1] & ~strb_sync_q[2];
  assign fsync_rise = fsync_sync_q[1] & ~fsync_sync_q[2];

  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      strb_sync_q   <= '0;
      fsync_sync_q  <= '0;
      phase_q       <= '0;
      g_q           <= '0;
      r_q           <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_bank_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
      overflow_q    <= 1'b0;
      pixel_count_q <= '0;
    end else begin
      strb_sync_q   <= {strb_sync_q[1:0], rx_strobe};
      fsync_sync_q  <= {fsync_sync_q[1:0], frame_sync};
      wr_en_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
      // Swap one cycle after frame_done so the last pixel lands in the old bank.
      if (frame_done_q) wr_bank_q <= ~wr_bank_q;

      case (state_q)
        IDLE: begin
          if (fsync_rise) begin
            state_q       <= RECV;
            phase_q       <= '0;
            pixel_count_q <= '0;
          end
        end
        RECV: begin
          // A sync rise wins over a coincident byte, which is dropped.
          if (fsync_rise) begin
            if ((pixel_count_q != '0) || (phase_q != 2'd0)) short_frame_q <= 1'b1;
            phase_q       <= '0;
            pixel_count_q <= '0;
          end else if (strb_rise) begin
            case (phase_q)
              2'd0: begin
                g_q     <= rx_data;
                phase_q <= 2'd1;
              end
              2'd1: begin
                r_q     <= rx_data;
                phase_q <= 2'd2;
              end
              default: begin
                wr_data_q     <= {r_q, g_q, rx_data};
                wr_addr_q     <= pixel_count_q;
                wr_en_q       <= 1'b1;
                pixel_count_q <= pixel_count_q + 1'b1;
                phase_q       <= 2'd0;
                if (pixel_count_q == LAST_PIX) begin
                  state_q      <= DONE;
                  frame_done_q <= 1'b1;
                end
              end
            endcase
          end
        end
        DONE: begin
          if (fsync_rise) begin
            state_q       <= RECV;
            phase_q       <= '0;
            pixel_count_q <= '0;
            overflow_q    <= 1'b0;
          end else if (strb_rise) begin
            overflow_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_bank     = wr_bank_q;
  assign frame_done  = frame_done_q;
  assign short_frame = short_frame_q;
  assign overflow    = overflow_q;
  assign pixel_count = pixel_count_q;

endmodule

// File: tb/tb_ws2812_pixel_writer.sv
// Scoreboard bench for ws2812_pixel_writer: a byte-level frame model predicts each
// RAM write (address, data, bank, cycle) and short-frame pulse; a monitor pops and compares.
module tb_ws2812_pixel_writer;
  localparam int NP = 4;
  localparam int AW = 3;

  logic          CLK_40 = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_strobe = 1'b0;
  logic          frame_sync = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          wr_bank;
  logic          frame_done;
  logic          short_frame;
  logic          overflow;
  logic [AW-1:0] pixel_count;

  ws2812_pixel_writer #(.NUM_PIXELS(NP), .ADDR_WIDTH(AW)) dut (
    .CLK_40(CLK_40), .reset(reset), .rx_data(rx_data), .rx_strobe(rx_strobe),
    .frame_sync(frame_sync), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_bank(wr_bank), .frame_done(frame_done), .short_frame(short_frame),
    .overflow(overflow), .pixel_count(pixel_count)
  );

  always #12 CLK_40 = ~CLK_40;

  int cyc = 0;
  always @(posedge CLK_40) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: frame-level view of the byte stream.
  typedef struct {
    int addr;
    int data;
    bit done;
    bit bank;
    int cyc;
  } wr_t;

  wr_t wq[$];
  int  sq[$];
  int  m_mode = 0;      // 0: no frame yet, 1: collecting, 2: frame full
  int  m_bytes[$];
  int  m_pix = 0;
  bit  m_bank = 1'b0;
  bit  m_ovf = 1'b0;

  function automatic void model_sync(input int c);
    if (m_mode == 1 && (m_pix != 0 || m_bytes.size() != 0)) sq.push_back(c + 3);
    m_pix = 0;
    m_bytes.delete();
    m_mode = 1;
    m_ovf = 1'b0;
  endfunction

  function automatic void model_byte(input int b, input int c);
    wr_t e;
    if (m_mode == 0) return;
    if (m_mode == 2) begin
      m_ovf = 1'b1;
      return;
    end
    m_bytes.push_back(b);
    if (m_bytes.size() == 3) begin
      e.addr = m_pix;
      e.data = (m_bytes[1] << 16) | (m_bytes[0] << 8) | m_bytes[2];
      e.done = (m_pix == NP - 1);
      e.bank = m_bank;
      e.cyc  = c + 3;
      wq.push_back(e);
      m_pix++;
      m_bytes.delete();
      if (e.done) begin
        m_mode = 2;
        m_bank = ~m_bank;
      end
    end
  endfunction

  function automatic void model_reset();
    m_mode = 0;
    m_pix = 0;
    m_bytes.delete();
    m_bank = 1'b0;
    m_ovf = 1'b0;
  endfunction

  // Monitor
  bit pend_flip = 1'b0;
  bit flip_val = 1'b0;
  always @(negedge CLK_40) begin
    wr_t e;
    int s;
    if (pend_flip) begin
      check("bank_toggle", 32'(wr_bank), 32'(flip_val));
      pend_flip = 1'b0;
    end
    if (wr_en) begin
      if (wq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_wr: got wr_en=1 addr %0d data %06h, expected no write (cycle %0d)",
                 wr_addr, wr_data, cyc);
      end else begin
        e = wq.pop_front();
        check("wr_cycle", 32'(cyc), 32'(e.cyc));
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
        check("wr_bank", 32'(wr_bank), 32'(e.bank));
        check("frame_done", 32'(frame_done), 32'(e.done));
        check("pixel_count_at_wr", 32'(pixel_count), 32'((e.addr + 1) % (1 << AW)));
        if (e.done) begin
          pend_flip = 1'b1;
          flip_val = ~e.bank;
        end
      end
    end else if (frame_done) begin
      check("frame_done_without_wr", 32'(frame_done), 32'd0);
    end
    if (short_frame) begin
      if (sq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_short: got short_frame=1, expected none (cycle %0d)", cyc);
      end else begin
        s = sq.pop_front();
        check("short_cycle", 32'(cyc), 32'(s));
      end
    end
  end

  task automatic send_byte(input int b, input int hi, input int lo);
    @(negedge CLK_40);
    rx_data = 8'(b);
    rx_strobe = 1'b1;
    model_byte(b, cyc);
    repeat (hi) @(negedge CLK_40);
    rx_strobe = 1'b0;
    repeat (lo) @(negedge CLK_40);
  endtask

  task automatic send_rand_bytes(input int n);
    for (int i = 0; i < n; i++)
      send_byte(int'($urandom_range(0, 255)), int'($urandom_range(2, 10)), int'($urandom_range(2, 6)));
  endtask

  task automatic send_sync(input int hi);
    @(negedge CLK_40);
    frame_sync = 1'b1;
    model_sync(cyc);
    repeat (hi) @(negedge CLK_40);
    frame_sync = 1'b0;
    repeat (3) @(negedge CLK_40);
  endtask

  task automatic send_sync_and_byte(input int b);
    @(negedge CLK_40);
    frame_sync = 1'b1;
    rx_data = 8'(b);
    rx_strobe = 1'b1;
    model_sync(cyc);
    repeat (8) @(negedge CLK_40);
    frame_sync = 1'b0;
    rx_strobe = 1'b0;
    repeat (4) @(negedge CLK_40);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check({tag, "_wr_bank"}, 32'(wr_bank), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_short_frame"}, 32'(short_frame), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_pixel_count"}, 32'(pixel_count), 32'd0);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_pixel_count"}, 32'(pixel_count), 32'(m_pix));
    check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_wr_bank"}, 32'(wr_bank), 32'(m_bank));
  endtask

  initial begin
    repeat (4) @(negedge CLK_40);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (3) @(negedge CLK_40);
    check_all_zero("idle");

    // Bytes before any sync are ignored.
    send_rand_bytes(4);
    check_status("pre_sync");

    // First pixel, then complete the frame.
    send_sync(4);
    send_byte(8'h11, 8, 4);
    send_byte(8'h22, 8, 4);
    send_byte(8'h33, 8, 4);
    check_status("first_pixel");
    send_rand_bytes(9);
    check_status("frame1");

    send_sync(4);
    send_rand_bytes(12);
    check_status("frame2");

    // Short frame, then restart at address 0.
    send_sync(4);
    send_rand_bytes(5);
    send_sync(4);
    check_status("after_short");
    send_rand_bytes(3);
    send_rand_bytes(9);
    check_status("frame3");

    // Overflow after a complete frame, cleared by sync.
    send_rand_bytes(1);
    check_status("overflow_set");
    send_sync(4);
    check_status("overflow_clr");

    // Coincident sync and strobe: sync wins, byte dropped.
    send_rand_bytes(2);
    send_sync_and_byte(8'hA5);
    send_byte(8'h01, 8, 4);
    send_byte(8'h02, 8, 4);
    send_byte(8'h03, 8, 4);
    check_status("coincident");

    for (int it = 0; it < 20; it++) begin
      send_sync(int'($urandom_range(2, 6)));
      send_rand_bytes(int'($urandom_range(0, 14)));
      check_status("random");
    end

    // Reset mid-frame.
    send_sync(4);
    send_rand_bytes(7);
    check("pre_reset_pending_wr", 32'(wq.size()), 32'd0);
    @(negedge CLK_40);
    #2 reset = 1'b1;
    model_reset();
    #1 check_all_zero("async_reset");
    repeat (3) @(negedge CLK_40);
    reset = 1'b0;
    repeat (2) @(negedge CLK_40);
    send_rand_bytes(4);
    check_status("post_reset_idle");
    send_sync(4);
    send_rand_bytes(12);
    check_status("post_reset_frame");

    repeat (10) @(negedge CLK_40);
    check("leftover_writes", 32'(wq.size()), 32'd0);
    check("leftover_shorts", 32'(sq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
